usb_uart_tx_fifo: RTL and testbench

//  Byte FIFO directly upstream of the USB UART core's device->host pipeline (uart_in_*).

---
 rtl/usb_uart_tx_fifo.sv | 125 ++++++++++++
 tb/tb_usb_uart_tx_fifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_uart_tx_fifo.sv
// usb_uart_tx_fifo: byte FIFO feeding the USB UART core's device->host stream.
// Storage is a (DEPTH-1)-entry RAM plus the registered output stage out_data/out_valid.
// A write into an otherwise empty FIFO bypasses the RAM and lands in the output register.
// Optional feature macro: USB_UART_TX_FIFO_OVF_EN adds overflow sticky flag and counter.
module usb_uart_tx_fifo #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk_48mhz,
  input  logic          reset,
  input  logic          flush,
  input  logic [7:0]    wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full
`ifdef USB_UART_TX_FIFO_OVF_EN
  ,
  output logic          ovf_sticky,
  output logic [15:0]   ovf_count
`endif
);

  localparam int            RAM_N    = DEPTH - 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 2);

  logic [7:0]    mem [RAM_N];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] ram_cnt;

  logic pop;
  logic wr_fire;
  logic load_out;
  logic ram_rd;
  logic ram_wr;
  logic bypass;

  // Pointers run over the DEPTH-1 RAM slots only.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + AW'(1);
  endfunction

  // Counter that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign level    = {1'b0, ram_cnt} + {{AW{1'b0}}, out_valid};
  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign wr_ready = ~full;

  // Transfer decode: output register refills whenever it is empty or being popped.
  always_comb begin
    pop      = out_valid & out_ready;
    wr_fire  = wr_valid & ~full;
    load_out = ~out_valid | pop;
    ram_rd   = load_out & (ram_cnt != '0);
    bypass   = load_out & (ram_cnt == '0) & wr_fire;
    ram_wr   = wr_fire & ~bypass;
  end

  // RAM write port; contents need no reset, flush only rewinds the pointers.
  always_ff @(posedge clk_48mhz) begin
    if (!flush && ram_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer, occupancy and output-register update.
  always_ff @(posedge clk_48mhz or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (ram_wr) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (ram_rd) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({ram_wr, ram_rd})
        2'b10:   ram_cnt <= ram_cnt + AW'(1);
        2'b01:   ram_cnt <= ram_cnt - AW'(1);
        default: ram_cnt <= ram_cnt;
      endcase
      if (ram_rd) begin
        out_data  <= mem[rd_ptr];
        out_valid <= 1'b1;
      end else if (bypass) begin
        out_data  <= wr_data;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef USB_UART_TX_FIFO_OVF_EN
  // Overflow statistics survive flush; only reset clears them.
  always_ff @(posedge clk_48mhz or negedge reset) begin
    if (!reset) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= 16'h0000;
    end else if (wr_valid && full && !flush) begin
      ovf_sticky <= 1'b1;
      ovf_count  <= sat_inc16(ovf_count);
    end
  end
`endif

endmodule

// File: tb/tb_usb_uart_tx_fifo.sv
// tb_usb_uart_tx_fifo: directed self-checking bench for usb_uart_tx_fifo (DEPTH=64).
// Overflow checks compile in when USB_UART_TX_FIFO_OVF_EN is defined.
module tb_usb_uart_tx_fifo;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] level;
  logic       empty;
  logic       full;
`ifdef USB_UART_TX_FIFO_OVF_EN
  logic       ovf_sticky;
  logic [15:0] ovf_count;
`endif

  int checks = 0;
  int passed = 0;

  usb_uart_tx_fifo #(.DEPTH(64), .AW(6)) dut (
    .clk_48mhz (clk),
    .reset     (reset),
    .flush     (flush),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .empty     (empty),
    .full      (full)
`ifdef USB_UART_TX_FIFO_OVF_EN
    ,
    .ovf_sticky(ovf_sticky),
    .ovf_count (ovf_count)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      flush     = 1'($urandom);
      wr_valid  = 1'($urandom);
      wr_data   = 8'($urandom);
      out_ready = 1'($urandom);
      tick();
    end
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b expected 0", out_valid); else passed++;
    checks++; if (level !== 7'd0) $display("FAIL reset_level: got %0d expected 0", level); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %0b expected 1", empty); else passed++;
    checks++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready: got %0b expected 1", wr_ready); else passed++;
    checks++; if (full !== 1'b0) $display("FAIL reset_full: got %0b expected 0", full); else passed++;
    checks++; if (out_data !== 8'h00) $display("FAIL reset_out_data: got %0h expected 00", out_data); else passed++;
`ifdef USB_UART_TX_FIFO_OVF_EN
    checks++; if (ovf_sticky !== 1'b0 || ovf_count !== 16'd0) $display("FAIL reset_ovf: got %0b/%0d expected 0/0", ovf_sticky, ovf_count); else passed++;
`endif
    flush = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; out_ready = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    wr_data = 8'hA5; wr_valid = 1'b1; out_ready = 1'b1;
    tick();
    wr_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %0b expected 1", out_valid); else passed++;
    checks++; if (out_data !== 8'hA5) $display("FAIL single_data: got %0h expected a5", out_data); else passed++;
    checks++; if (level !== 7'd1) $display("FAIL single_level: got %0d expected 1", level); else passed++;
    tick();
    checks++; if (empty !== 1'b1 || out_valid !== 1'b0) $display("FAIL single_drained: got empty=%0b valid=%0b expected 1/0", empty, out_valid); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic fill_64(input logic [7:0] base);
    out_ready = 1'b0;
    wr_valid  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      wr_data = base + 8'(i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_fill_drain();
    fill_64(8'h00);
    checks++; if (full !== 1'b1) $display("FAIL fill_full: got %0b expected 1", full); else passed++;
    checks++; if (level !== 7'd64) $display("FAIL fill_level: got %0d expected 64", level); else passed++;
    checks++; if (wr_ready !== 1'b0) $display("FAIL fill_wr_ready: got %0b expected 0", wr_ready); else passed++;
    wr_data = 8'hFF; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    checks++; if (level !== 7'd64) $display("FAIL drop_level: got %0d expected 64", level); else passed++;
    checks++; if (out_data !== 8'h00) $display("FAIL drop_head: got %0h expected 00", out_data); else passed++;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(i))
        $display("FAIL drain_byte%0d: got valid=%0b data=%0h expected 1/%0h", i, out_valid, out_data, 8'(i));
      else passed++;
      tick();
    end
    checks++; if (empty !== 1'b1 || out_valid !== 1'b0) $display("FAIL drain_empty: got empty=%0b valid=%0b expected 1/0", empty, out_valid); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_full_pop_write();
    fill_64(8'h40);
    out_ready = 1'b1; wr_valid = 1'b1; wr_data = 8'hEE;
    checks++; if (wr_ready !== 1'b0) $display("FAIL fpw_wr_ready: got %0b expected 0", wr_ready); else passed++;
    tick();
    wr_valid = 1'b0;
    checks++; if (level !== 7'd63) $display("FAIL fpw_level: got %0d expected 63", level); else passed++;
    for (int i = 1; i < 64; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h40 + 8'(i))
        $display("FAIL fpw_byte%0d: got valid=%0b data=%0h expected 1/%0h", i, out_valid, out_data, 8'h40 + 8'(i));
      else passed++;
      tick();
    end
    checks++; if (empty !== 1'b1) $display("FAIL fpw_empty: got %0b expected 1", empty); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    int sent = 0;
    int recv = 0;
    int cyc  = 0;
    logic stall_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;
    while (recv < 1000 && cyc < 20000) begin
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== data_prev)
          $display("FAIL stream_hold: got valid=%0b data=%0h expected 1/%0h", out_valid, out_data, data_prev);
        else passed++;
      end
      checks++;
      if (level !== 7'(q.size())) $display("FAIL stream_level: got %0d expected %0d", level, q.size()); else passed++;
      wr_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      wr_data   = 8'(sent * 7 + 3);
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL stream_spurious: got %0h expected none", out_data);
        end else begin
          if (out_data !== q[0]) $display("FAIL stream_order%0d: got %0h expected %0h", recv, out_data, q[0]); else passed++;
          void'(q.pop_front());
        end
        recv++;
      end
      if (wr_valid && wr_ready) begin
        q.push_back(wr_data);
        sent++;
      end
      stall_prev = out_valid & ~out_ready;
      data_prev  = out_data;
      tick();
      cyc++;
    end
    checks++; if (recv !== 1000) $display("FAIL stream_timeout: got %0d bytes expected 1000", recv); else passed++;
    wr_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_flush();
    wr_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_data = 8'h10 + 8'(i);
      tick();
    end
    checks++; if (level !== 7'd10) $display("FAIL flush_pre_level: got %0d expected 10", level); else passed++;
    flush = 1'b1; wr_data = 8'h77; out_ready = 1'b1;
    tick();
    flush = 1'b0; wr_valid = 1'b0; out_ready = 1'b0;
    checks++; if (level !== 7'd0) $display("FAIL flush_level: got %0d expected 0", level); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %0b expected 0", out_valid); else passed++;
    checks++; if (out_data !== 8'h10) $display("FAIL flush_data_hold: got %0h expected 10", out_data); else passed++;
    wr_data = 8'h3C; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C) $display("FAIL flush_first: got valid=%0b data=%0h expected 1/3c", out_valid, out_data); else passed++;
    checks++; if (level !== 7'd1) $display("FAIL flush_post_level: got %0d expected 1", level); else passed++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (empty !== 1'b1) $display("FAIL flush_drained: got %0b expected 1", empty); else passed++;
  endtask

`ifdef USB_UART_TX_FIFO_OVF_EN
  task automatic test_ovf();
    fill_64(8'h80);
    wr_valid = 1'b1; wr_data = 8'hFF;
    for (int i = 0; i < 5; i++) tick();
    wr_valid = 1'b0;
    checks++; if (ovf_count !== 16'd5) $display("FAIL ovf_count: got %0d expected 5", ovf_count); else passed++;
    checks++; if (ovf_sticky !== 1'b1) $display("FAIL ovf_sticky: got %0b expected 1", ovf_sticky); else passed++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (ovf_count !== 16'd5 || ovf_sticky !== 1'b1) $display("FAIL ovf_flush: got %0b/%0d expected 1/5", ovf_sticky, ovf_count); else passed++;
    reset = 1'b0;
    #1;
    checks++; if (ovf_count !== 16'd0 || ovf_sticky !== 1'b0) $display("FAIL ovf_reset: got %0b/%0d expected 0/0", ovf_sticky, ovf_count); else passed++;
    tick();
    reset = 1'b1;
    tick();
  endtask
`endif

  initial begin
    reset = 1'b0; flush = 1'b0; wr_data = 8'h00; wr_valid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_fill_drain();
    test_full_pop_write();
    test_back_to_back();
    test_flush();
`ifdef USB_UART_TX_FIFO_OVF_EN
    test_ovf();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
